// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D main-memory arbiter: FSM state encodings,
// owner encodings and the alternating-priority winner select.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arbState_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // With both sides asking, the side that did not win last time goes next;
   // a lone requester always wins.
   function automatic owner_e pickWinner(input logic iCand, input logic dCand,
                                         input owner_e lastGrant);
      if (iCand && dCand)
         return (lastGrant == OWN_I) ? OWN_D : OWN_I;
      else if (dCand)
         return OWN_D;
      else
         return OWN_I;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch-side, data-side and memory-side signals of the arbiter.
// slave  : the arbiter itself.
// master : requesters plus the memory model driving the arbiter.
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_done;
   logic [DW-1:0] i_rdata;
   logic          i_stall;

   logic          d_req;
   logic          d_wr;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_done;
   logic [DW-1:0] d_rdata;
   logic          d_stall;

   logic          mem_rd;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      output i_done, i_rdata, i_stall, d_done, d_rdata, d_stall,
             mem_rd, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      input  i_done, i_rdata, i_stall, d_done, d_rdata, d_stall,
             mem_rd, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down-counter that times the memory latency. last flags cnt==1,
// the final WAIT cycle before the result is ready.
module mem_arbiter_lat_counter #(
   parameter int MEM_LAT = 4,
   localparam int CW     = $clog2(MEM_LAT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] loadVal,
   input  logic          dec,
   output logic          last
);
   logic [CW-1:0] cnt;

   // Load wins over decrement; the count never wraps below zero.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= loadVal;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign last = (cnt == CW'(1));
endmodule

// File: rtl/mem_arbiter.sv
// Unified main-memory arbiter between fetch (read-only) and memory stage
// (read/write). One access in flight at a time; alternating priority on
// conflict; per-side done pulse and stall.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_LAT = 4,
   parameter int AW      = 16,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   localparam int            CW       = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

   arbState_e     state, nextState;
   owner_e        owner, lastGrant, winner;
   logic [AW-1:0] latAddr;
   logic [DW-1:0] latWdata;
   logic          latWr;

   logic          iCand, dCand, grant;
   logic          cntLoad, cntDec, cntLast;
   logic          issueCyc, doneCyc;

   mem_arbiter_lat_counter #(.MEM_LAT(MEM_LAT)) latCnt (
      .clk     (clk),
      .rst     (rst),
      .load    (cntLoad),
      .loadVal (LOAD_VAL),
      .dec     (cntDec),
      .last    (cntLast)
   );

   // In DONE the owner's request is still up from the finishing access, so it
   // is masked; if it is really a new access it is seen again from IDLE.
   always_comb begin
      iCand  = bus.i_req && !((state == DONE) && (owner == OWN_I));
      dCand  = bus.d_req && !((state == DONE) && (owner == OWN_D));
      winner = pickWinner(iCand, dCand, lastGrant);
   end

   // Next-state and counter control.
   always_comb begin
      nextState = state;
      grant     = 1'b0;
      cntLoad   = 1'b0;
      cntDec    = 1'b0;
      unique case (state)
         IDLE: begin
            if (iCand || dCand) begin
               grant     = 1'b1;
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            cntLoad   = 1'b1;
            nextState = (MEM_LAT > 1) ? WAIT : DONE;
         end
         WAIT: begin
            cntDec = 1'b1;
            if (cntLast)
               nextState = DONE;
         end
         DONE: begin
            if (iCand || dCand) begin
               grant     = 1'b1;
               nextState = ISSUE;
            end else begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // State register plus the latched request of the granted side; the latch
   // is only written on a grant so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OWN_I;
         lastGrant <= OWN_I;
         latAddr   <= '0;
         latWdata  <= '0;
         latWr     <= 1'b0;
      end else begin
         state <= nextState;
         if (grant) begin
            owner     <= winner;
            lastGrant <= winner;
            if (winner == OWN_D) begin
               latAddr  <= bus.d_addr;
               latWdata <= bus.d_wdata;
               latWr    <= bus.d_wr;
            end else begin
               latAddr  <= bus.i_addr;
               latWdata <= '0;
               latWr    <= 1'b0;
            end
         end
      end
   end

   // Commands and done pulses are masked while rst is high so an abort never
   // leaks a pulse during the reset cycle itself.
   assign issueCyc      = (state == ISSUE) && !rst;
   assign doneCyc       = (state == DONE)  && !rst;

   assign bus.mem_rd    = issueCyc && !latWr;
   assign bus.mem_wr    = issueCyc &&  latWr;
   assign bus.mem_addr  = latAddr;
   assign bus.mem_wdata = latWdata;

   assign bus.i_done    = doneCyc && (owner == OWN_I);
   assign bus.d_done    = doneCyc && (owner == OWN_D);
   assign bus.i_rdata   = bus.i_done ? bus.mem_rdata : '0;
   assign bus.d_rdata   = (bus.d_done && !latWr) ? bus.mem_rdata : '0;

   assign bus.i_stall   = bus.i_req && !bus.i_done;
   assign bus.d_stall   = bus.d_req && !bus.d_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one MEM_LAT=4 instance (A) and one
// MEM_LAT=1 instance (B), each with a small latency-accurate memory model.
module tb_mem_arbiter;
   localparam int LATA = 4;
   localparam int LATB = 1;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } doneExp_t;

   typedef struct {
      int          cyc;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } cmdExp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc   = 0;
   int   nChk  = 0;
   int   nFail = 0;

   doneExp_t doneQ [4][$];   // index = dut*2 + side (side 0 = I, 1 = D)
   cmdExp_t  cmdQ  [2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter_if #(.AW(16), .DW(16)) ifA ();
   mem_arbiter_if #(.AW(16), .DW(16)) ifB ();

   mem_arbiter #(.MEM_LAT(LATA), .AW(16), .DW(16)) dutA (.clk(clk), .rst(rst), .bus(ifA));
   mem_arbiter #(.MEM_LAT(LATB), .AW(16), .DW(16)) dutB (.clk(clk), .rst(rst), .bus(ifB));

   // Memory models: read data appears MEM_LAT cycles after the command cycle.
   logic [15:0] memA [0:1023];
   logic [15:0] memB [0:1023];
   logic [15:0] pipeA [LATA];
   logic [15:0] pipeB [LATB];
   assign ifA.mem_rdata = pipeA[LATA-1];
   assign ifB.mem_rdata = pipeB[LATB-1];

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LATA; k++) pipeA[k] <= 16'h0;
         memA[10'h010] <= 16'hBEEF; memA[10'h012] <= 16'h1212;
         memA[10'h040] <= 16'h4444; memA[10'h200] <= 16'hA200;
         memA[10'h202] <= 16'hA202;
      end else begin
         if (ifA.mem_wr) memA[ifA.mem_addr[9:0]] <= ifA.mem_wdata;
         pipeA[0] <= ifA.mem_rd ? memA[ifA.mem_addr[9:0]] : 16'h0;
         for (int k = 1; k < LATA; k++) pipeA[k] <= pipeA[k-1];
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LATB; k++) pipeB[k] <= 16'h0;
         memB[10'h010] <= 16'hBEEF; memB[10'h012] <= 16'h1212;
         memB[10'h040] <= 16'h4444;
      end else begin
         if (ifB.mem_wr) memB[ifB.mem_addr[9:0]] <= ifB.mem_wdata;
         pipeB[0] <= ifB.mem_rd ? memB[ifB.mem_addr[9:0]] : 16'h0;
         for (int k = 1; k < LATB; k++) pipeB[k] <= pipeB[k-1];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChk++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever a done pulse or memory command shows.
   always @(negedge clk) begin : mon
      logic        dn [4];
      logic [15:0] dd [4];
      logic        cr [2];
      logic        cw [2];
      logic [15:0] ca [2];
      logic [15:0] cd [2];
      dn[0] = ifA.i_done; dd[0] = ifA.i_rdata; dn[1] = ifA.d_done; dd[1] = ifA.d_rdata;
      dn[2] = ifB.i_done; dd[2] = ifB.i_rdata; dn[3] = ifB.d_done; dd[3] = ifB.d_rdata;
      cr[0] = ifA.mem_rd; cw[0] = ifA.mem_wr; ca[0] = ifA.mem_addr; cd[0] = ifA.mem_wdata;
      cr[1] = ifB.mem_rd; cw[1] = ifB.mem_wr; ca[1] = ifB.mem_addr; cd[1] = ifB.mem_wdata;
      for (int k = 0; k < 4; k++) begin
         if (dn[k]) begin
            if (doneQ[k].size() == 0) begin
               nChk++; nFail++;
               $display("FAIL unexpected done on port %0d at cycle %0d", k, cyc);
            end else begin
               doneExp_t e;
               e = doneQ[k].pop_front();
               chk($sformatf("done%0d cycle", k), cyc, e.cyc);
               chk($sformatf("done%0d rdata", k), {16'h0, dd[k]}, {16'h0, e.data});
            end
         end
      end
      for (int j = 0; j < 2; j++) begin
         if (cr[j] || cw[j]) begin
            if (cmdQ[j].size() == 0) begin
               nChk++; nFail++;
               $display("FAIL unexpected mem command on dut %0d at cycle %0d", j, cyc);
            end else begin
               cmdExp_t e;
               e = cmdQ[j].pop_front();
               chk($sformatf("cmd%0d cycle", j), cyc, e.cyc);
               chk($sformatf("cmd%0d mem_wr", j), {31'h0, cw[j]}, {31'h0, e.wr});
               chk($sformatf("cmd%0d mem_rd", j), {31'h0, cr[j]}, {31'h0, !e.wr});
               chk($sformatf("cmd%0d mem_addr", j), {16'h0, ca[j]}, {16'h0, e.addr});
               if (e.wr) chk($sformatf("cmd%0d mem_wdata", j), {16'h0, cd[j]}, {16'h0, e.wdata});
            end
         end
      end
   end

   task automatic expAcc(input int dut, input int side, input int issueCyc, input int doneCyc,
                         input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [15:0] data);
      cmdExp_t  c;
      doneExp_t d;
      c.cyc = issueCyc; c.wr = wr; c.addr = addr; c.wdata = wd;
      d.cyc = doneCyc;  d.data = data;
      cmdQ[dut].push_back(c);
      doneQ[dut*2+side].push_back(d);
   endtask

   task automatic drive(input int dut, input int side, input logic req, input logic wr,
                        input logic [15:0] addr, input logic [15:0] wd);
      if (dut == 0) begin
         if (side == 0) begin ifA.i_req = req; ifA.i_addr = addr; end
         else begin ifA.d_req = req; ifA.d_wr = wr; ifA.d_addr = addr; ifA.d_wdata = wd; end
      end else begin
         if (side == 0) begin ifB.i_req = req; ifB.i_addr = addr; end
         else begin ifB.d_req = req; ifB.d_wr = wr; ifB.d_addr = addr; ifB.d_wdata = wd; end
      end
   endtask

   function automatic logic doneOf(input int dut, input int side);
      if (dut == 0) return (side == 0) ? ifA.i_done : ifA.d_done;
      return (side == 0) ? ifB.i_done : ifB.d_done;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the request until done (bounded), then drop it the next cycle.
   task automatic finishAcc(input int dut, input int side);
      logic seen = 1'b0;
      for (int n = 0; n < 60 && !seen; n++) begin
         @(negedge clk);
         seen = doneOf(dut, side);
      end
      chk($sformatf("done wait dut%0d side%0d", dut, side), {31'h0, seen}, 32'h1);
      tick(1);
      drive(dut, side, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic access(input int dut, input int side, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wd);
      drive(dut, side, 1'b1, wr, addr, wd);
      finishAcc(dut, side);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst = 1'b1;
      drive(0, 0, 1'b0, 1'b0, 16'h0, 16'h0); drive(0, 1, 1'b0, 1'b0, 16'h0, 16'h0);
      drive(1, 0, 1'b0, 1'b0, 16'h0, 16'h0); drive(1, 1, 1'b0, 1'b0, 16'h0, 16'h0);

      // Reset with both requests up: every output stays 0.
      drive(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0);
      drive(0, 1, 1'b1, 1'b0, 16'h0040, 16'h0);
      tick(1);
      @(negedge clk);
      chk("rst i_done", {31'h0, ifA.i_done}, 32'h0);
      chk("rst d_done", {31'h0, ifA.d_done}, 32'h0);
      chk("rst mem_rd", {31'h0, ifA.mem_rd}, 32'h0);
      chk("rst mem_wr", {31'h0, ifA.mem_wr}, 32'h0);
      chk("rst mem_addr", {16'h0, ifA.mem_addr}, 32'h0);
      chk("rst mem_wdata", {16'h0, ifA.mem_wdata}, 32'h0);
      chk("rst i_rdata", {16'h0, ifA.i_rdata}, 32'h0);
      chk("rst d_rdata", {16'h0, ifA.d_rdata}, 32'h0);
      tick(1);
      rst = 1'b0;
      // First grant after reset goes to D, then I.
      t = cyc;
      expAcc(0, 1, t+1, t+5,  1'b0, 16'h0040, 16'h0, 16'h4444);
      expAcc(0, 0, t+6, t+10, 1'b0, 16'h0010, 16'h0, 16'hBEEF);
      fork
         finishAcc(0, 1);
         finishAcc(0, 0);
      join
      tick(2);

      // I-only read with stall profile.
      t = cyc;
      expAcc(0, 0, t+1, t+5, 1'b0, 16'h0010, 16'h0, 16'hBEEF);
      fork
         access(0, 0, 1'b0, 16'h0010, 16'h0);
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("i_stall t+%0d", c), {31'h0, ifA.i_stall}, (c < 5) ? 32'h1 : 32'h0);
         end
      join
      tick(2);

      // Both held for two accesses each: grants alternate D, I, D, I.
      t = cyc;
      expAcc(0, 1, t+1,  t+5,  1'b0, 16'h0200, 16'h0, 16'hA200);
      expAcc(0, 0, t+6,  t+10, 1'b0, 16'h0010, 16'h0, 16'hBEEF);
      expAcc(0, 1, t+11, t+15, 1'b0, 16'h0202, 16'h0, 16'hA202);
      expAcc(0, 0, t+16, t+20, 1'b0, 16'h0012, 16'h0, 16'h1212);
      fork
         begin access(0, 1, 1'b0, 16'h0200, 16'h0); access(0, 1, 1'b0, 16'h0202, 16'h0); end
         begin access(0, 0, 1'b0, 16'h0010, 16'h0); access(0, 0, 1'b0, 16'h0012, 16'h0); end
      join
      tick(2);

      // D write: d_rdata is 0 and the address/data latch holds through DONE.
      t = cyc;
      expAcc(0, 1, t+1, t+5, 1'b1, 16'h0300, 16'h1234, 16'h0000);
      fork
         access(0, 1, 1'b1, 16'h0300, 16'h1234);
         begin
            @(negedge clk);
            for (int c = 1; c <= 5; c++) begin
               @(negedge clk);
               chk($sformatf("mem_addr t+%0d", c), {16'h0, ifA.mem_addr}, 32'h0300);
               chk($sformatf("mem_wdata t+%0d", c), {16'h0, ifA.mem_wdata}, 32'h1234);
            end
         end
      join
      tick(2);
      t = cyc;
      expAcc(0, 1, t+1, t+5, 1'b0, 16'h0300, 16'h0, 16'h1234);
      access(0, 1, 1'b0, 16'h0300, 16'h0);
      tick(2);

      // Reset during WAIT: command issues, no done follows, latch cleared.
      t = cyc;
      cmdQ[0].push_back('{t+1, 1'b0, 16'h0040, 16'h0});
      drive(0, 0, 1'b1, 1'b0, 16'h0040, 16'h0);
      tick(3);
      rst = 1'b1;
      drive(0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      chk("abort mem_addr", {16'h0, ifA.mem_addr}, 32'h0);
      tick(4);
      t = cyc;
      expAcc(0, 1, t+1, t+5, 1'b0, 16'h0040, 16'h0, 16'h4444);
      access(0, 1, 1'b0, 16'h0040, 16'h0);
      tick(2);

      // MEM_LAT=1 instance: single read, then D,I,D back to back.
      t = cyc;
      expAcc(1, 0, t+1, t+2, 1'b0, 16'h0010, 16'h0, 16'hBEEF);
      access(1, 0, 1'b0, 16'h0010, 16'h0);
      tick(2);
      t = cyc;
      expAcc(1, 1, t+1, t+2, 1'b0, 16'h0040, 16'h0,    16'h4444);
      expAcc(1, 0, t+3, t+4, 1'b0, 16'h0012, 16'h0,    16'h1212);
      expAcc(1, 1, t+5, t+6, 1'b1, 16'h0050, 16'h5555, 16'h0000);
      fork
         begin access(1, 1, 1'b0, 16'h0040, 16'h0); access(1, 1, 1'b1, 16'h0050, 16'h5555); end
         access(1, 0, 1'b0, 16'h0012, 16'h0);
      join
      tick(3);

      for (int k = 0; k < 4; k++) chk($sformatf("doneQ%0d drained", k), doneQ[k].size(), 32'h0);
      for (int j = 0; j < 2; j++) chk($sformatf("cmdQ%0d drained", j), cmdQ[j].size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
      $finish;
   end
endmodule
